gpo_timed_dispatcher: RTL
=========================

Name: gpo_timed_dispatcher

Overview:
Producer end of the timed GPO bus. Pops 128-bit timed entries from an instruction FIFO, holds each until a free-running 64-bit timestamp counter equals the entry's timestamp field, then presents the entry on gpo_in and pulses counter_matched to all gpo channel cores. Entries that arrive after their time are dropped and reported as late errors.

Parameters:
TS_WIDTH, 64, timestamp field and counter width; entry bits [95:32]
MIN_GAP, 3, minimum timestamp spacing in counter ticks between consecutive entries; fixed by FSM latency

Ports:
CLK100MHZ  input  1  system clock
reset  input  1  asynchronous, active-high reset
run  input  1  counter increments by 1 each cycle while high
counter_clear  input  1  synchronous counter clear; takes priority over run
fifo_dout  input  128  FIFO read data, valid one cycle after fifo_rd_en
fifo_empty  input  1  FIFO empty flag
fifo_rd_en  output  1  FIFO pop strobe
gpo_in  output  128  entry broadcast to channel cores: [127:96] dest/upper data, [95:32] timestamp, [31:0] data
counter_matched  output  1  one-cycle strobe qualifying gpo_in
counter_value  output  64  current counter
late_error  output  1  sticky late-entry flag
late_data  output  128  first late entry since last clear
error_clear  input  1  clears late_error and late_data

Behaviour:
- Reset (async): state IDLE, counter 0, gpo_in 0, counter_matched 0, late_error 0, late_data 0, fifo_rd_en 0.
- Counter: counter_clear -> 0 next cycle; else run -> +1; wraps 2^64-1 -> 0 silently.
- FSM states: IDLE, LOAD, WAIT.
- IDLE: fifo_rd_en = (state==IDLE) & ~fifo_empty (combinational). Popping -> LOAD; else stay IDLE.
- LOAD: latch fifo_dout into entry_reg -> WAIT.
- WAIT, evaluated each cycle against the registered counter:
  - counter == ts: next cycle gpo_in <= entry_reg, counter_matched <= 1 for exactly one cycle; -> IDLE.
  - counter > ts: late. If late_error == 0, late_data <= entry_reg. late_error <= 1. Entry dropped with no strobe; -> IDLE.
  - otherwise: stay in WAIT. Also stay when run is low.
- gpo_in holds its last value between strobes; consumers use it only when counter_matched is high.
- Throughput: match at counter T, next compare at T+3. Timestamps with spacing < MIN_GAP are reported late.
- error_clear: clears late_error and late_data in the same cycle. If a late event occurs in the same cycle, the late event wins: flag set, new data captured.
- counter_clear while in WAIT: the comparison uses the new counter on following cycles, so a pending entry whose ts exceeds the new counter keeps waiting.
- Reset mid-WAIT: entry discarded; no strobe.
- fifo_rd_en is never asserted outside IDLE and never asserted while fifo_empty is high.

Decomposition:
- Package gpo_dispatch_pkg: state enum (IDLE/LOAD/WAIT), field slice constants (TS_MSB=95, TS_LSB=32, DEST_LSB=96, DATA_MSB=31), entry typedef of 128 bits.
- One sub-module, gpo_ts_counter: the 64-bit counter with clear, run and async reset.
- FSM, entry register and error capture stay in the top module.

Test Plan:
- Reset, then push entry ts=10, dest=3, data=0xDEADBEEF; run=1 from counter 0 -> counter_matched one cycle after counter==10; gpo_in[31:0]=0xDEADBEEF; gpo_in[96+:12]=3; fifo_rd_en pulsed once.
- Entries ts=20 and ts=23, back to back -> two strobes exactly 3 cycles apart; late_error stays 0.
- Entries ts=20 and ts=22 -> first fires; second dropped; late_error=1; late_data=second entry; only one strobe.
- Run held low with counter at 5 and entry ts=5 loaded -> single strobe; no repeat while state returns to IDLE with FIFO empty.
- Late entry ts=2 with counter=100, then a second late entry, then error_clear -> late_data holds the first late entry until cleared; after clear both late_error and late_data read 0.
- Entry ts=50 pending at counter 40, then counter_clear -> strobe at the new counter==50; assert reset at counter 45 during a later WAIT -> no strobe and all outputs at 0.

Source files
------------

// File: rtl/gpo_timed_dispatcher_pkg.sv
// Shared types and field layout for the timed GPO dispatcher.
// Entries are 128 bits: dest/upper data, 64-bit timestamp, 32-bit data.
package gpo_dispatch_pkg;

    localparam int TS_WIDTH = 64;
    localparam int MIN_GAP  = 3;

    localparam int TS_MSB   = 95;
    localparam int TS_LSB   = 32;
    localparam int DEST_LSB = 96;
    localparam int DATA_MSB = 31;

    typedef logic [127:0] entry_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT
    } state_t;

endpackage

// File: rtl/gpo_timed_dispatcher_if.sv
// FIFO read side and GPO broadcast bus of the dispatcher.
// master = dispatcher, slave = FIFO plus channel cores.
interface gpo_timed_dispatcher_if;
    import gpo_dispatch_pkg::*;

    entry_t fifo_dout;
    logic   fifo_empty;
    logic   fifo_rd_en;
    entry_t gpo_in;
    logic   counter_matched;

    modport master (
        input  fifo_dout,
        input  fifo_empty,
        output fifo_rd_en,
        output gpo_in,
        output counter_matched
    );

    modport slave (
        output fifo_dout,
        output fifo_empty,
        input  fifo_rd_en,
        input  gpo_in,
        input  counter_matched
    );

endinterface

// File: rtl/gpo_timed_dispatcher_ts_counter.sv
// Free-running timestamp counter; clear beats run, wraps silently.
module gpo_ts_counter #(
    parameter int WIDTH = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_run) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/gpo_timed_dispatcher.sv
// Pops timed entries from the FIFO and broadcasts each when the counter
// reaches its timestamp; entries already in the past are reported late.
module gpo_timed_dispatcher
    import gpo_dispatch_pkg::*;
#(
    parameter int TS_W = TS_WIDTH
) (
    input  logic                   CLK100MHZ,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   counter_clear,
    input  logic                   error_clear,
    gpo_timed_dispatcher_if.master gpo,
    output logic [TS_W-1:0]        counter_value,
    output logic                   late_error,
    output entry_t                 late_data
);

    state_t r_state;
    state_t w_next;

    entry_t r_entry;
    entry_t r_gpo;
    entry_t r_late_data;
    logic   r_matched;
    logic   r_late_error;

    logic            w_rd;
    logic            w_load;
    logic            w_match;
    logic            w_late;
    logic [TS_W-1:0] w_cnt;
    logic [TS_W-1:0] w_ts;

    gpo_ts_counter #(
        .WIDTH (TS_W)
    ) u_counter (
        .i_clk   (CLK100MHZ),
        .i_rst   (reset),
        .i_run   (run),
        .i_clear (counter_clear),
        .o_count (w_cnt)
    );

    assign w_ts = r_entry[TS_MSB:TS_LSB];

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_rd    = 1'b0;
        w_load  = 1'b0;
        w_match = 1'b0;
        w_late  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!gpo.fifo_empty) begin
                    w_rd   = 1'b1;
                    w_next = LOAD;
                end
            end
            LOAD: begin
                w_load = 1'b1;
                w_next = WAIT;
            end
            WAIT: begin
                // Unsigned compare: a counter past the timestamp means late.
                if (w_cnt == w_ts) begin
                    w_match = 1'b1;
                    w_next  = IDLE;
                end else if (w_cnt > w_ts) begin
                    w_late = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_entry      <= '0;
            r_gpo        <= '0;
            r_matched    <= 1'b0;
            r_late_error <= 1'b0;
            r_late_data  <= '0;
        end else begin
            if (w_load) begin
                r_entry <= gpo.fifo_dout;
            end
            r_matched <= w_match;
            if (w_match) begin
                r_gpo <= r_entry;
            end
            // A late event in the clear cycle wins and recaptures.
            if (w_late) begin
                r_late_error <= 1'b1;
                if (!r_late_error || error_clear) begin
                    r_late_data <= r_entry;
                end
            end else if (error_clear) begin
                r_late_error <= 1'b0;
                r_late_data  <= '0;
            end
        end
    end

    assign gpo.fifo_rd_en      = w_rd;
    assign gpo.gpo_in          = r_gpo;
    assign gpo.counter_matched = r_matched;
    assign counter_value       = w_cnt;
    assign late_error          = r_late_error;
    assign late_data           = r_late_data;

endmodule
